// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / uart_tx write-port bundle for uart_tx_arbiter.
// slave = arbiter view; master = environment (sources plus uart_tx FIFO).
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_wreq;
   logic                 tx_wgnt;
   logic [7:0]           tx_wdata;

   modport slave (
      input  req_valid, req_data, req_last, tx_wgnt,
      output req_ready, tx_wreq, tx_wdata
   );

   modport master (
      output req_valid, req_data, req_last, tx_wgnt,
      input  req_ready, tx_wreq, tx_wdata
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic sharing of the debug uart_tx write port among NUM_REQ byte sources.
// Optional forced release of a stalled grant: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int GW            = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_tx_arbiter_if.slave     bus,
   output logic [GW-1:0]        grant_id,
   output logic                 busy,
   output logic                 timeout_evt
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_q, last_d;

   logic            pick_vld;
   logic [GW-1:0]   pick_idx;

   logic [NUM_REQ-1:0] ready;
   logic               wreq;
   logic [7:0]         wdata;
   logic               xfer;
   logic               tmo;

`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
`endif

   // First valid source after the last granted one, wrapping modulo NUM_REQ.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (int'(last_q) + k) % NUM_REQ;
         if (!pick_vld && bus.req_valid[idx]) begin
            pick_vld = 1'b1;
            pick_idx = GW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      ready   = '0;
      wreq    = 1'b0;
      wdata   = 8'h00;
      busy    = 1'b0;
      xfer    = 1'b0;
      tmo     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d   = 16'd0;
`endif
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            busy           = 1'b1;
            wreq           = bus.req_valid[grant_q];
            wdata          = bus.req_data[{grant_q, 3'b000} +: 8];
            ready[grant_q] = bus.tx_wgnt & bus.req_valid[grant_q];
            xfer           = wreq & bus.tx_wgnt;
            if (xfer && bus.req_last[grant_q]) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            // A transfer in the same cycle as expiry wins over the timeout.
            cnt_d = xfer ? 16'd0 : cnt_q + 16'd1;
            if (!xfer && cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
               tmo     = 1'b1;
               last_d  = grant_q;
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GW'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 16'd0;
      else       cnt_q <= cnt_d;
   end
`endif

   assign bus.req_ready = ready;
   assign bus.tx_wreq   = wreq;
   assign bus.tx_wdata  = wdata;
   assign grant_id      = grant_q;
   assign timeout_evt   = tmo;

endmodule
